frame_ctrl: RTL and testbench

FRAME_CTRL -- requirements
Module: frame_ctrl

---
 rtl/frame_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_frame_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_ctrl.sv
// frame_ctrl: pulls SOF-delimited request frames from an RX FIFO, drives an external ALU and
// answers with SOF/result/status. Define FRAME_CTRL_CHECKSUM_EN for 5-byte frames with an XOR checksum.
module frame_ctrl #(
    parameter int                 NB_DATA       = 8,
    parameter int                 NB_OPCODE     = 6,
    parameter logic [NB_DATA-1:0] SOF_BYTE      = 8'hA5,
    parameter int                 NB_TIMEOUT    = 20,
    parameter int                 TIMEOUT_LIMIT = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_data_to_read,
    input  logic                 i_fifo_rx_empty,
    input  logic                 i_fifo_tx_full,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic                 o_fifo_rx_read,
    output logic                 o_fifo_tx_write,
    output logic [NB_DATA-1:0]   o_data_to_write,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    output logic [NB_DATA-1:0]   o_alu_op_A,
    output logic [NB_DATA-1:0]   o_alu_op_B,
    output logic                 o_busy,
    output logic [7:0]           o_err_count
);

    typedef enum logic [3:0] {
        IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, SEND_SOF, SEND_RES, SEND_STAT
    } state_t;

    localparam logic [NB_DATA-1:0]    ST_OK    = NB_DATA'(0);
    localparam logic [NB_DATA-1:0]    ST_CHK   = NB_DATA'(1);
    localparam logic [NB_DATA-1:0]    ST_OPC   = NB_DATA'(2);
    localparam logic [NB_DATA-1:0]    ST_TMO   = NB_DATA'(3);
    localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT_LIMIT - 1);

    state_t                state_q, state_d;
    logic [NB_DATA-1:0]    op_byte_q, op_byte_d;
    logic [NB_DATA-1:0]    a_q, a_d;
`ifdef FRAME_CTRL_CHECKSUM_EN
    logic [NB_DATA-1:0]    b_q, b_d;
    logic [NB_DATA-1:0]    chk_q, chk_d;
    logic                  chk_bad;
`endif
    logic [NB_DATA-1:0]    status_q, status_d;
    logic [NB_DATA-1:0]    result_q, result_d;
    logic [NB_TIMEOUT-1:0] tmo_q, tmo_d;
    logic [7:0]            err_q, err_d;
    logic                  run_q, run_d;
    logic [NB_OPCODE-1:0]  alu_opcode_q, alu_opcode_d;
    logic [NB_DATA-1:0]    alu_a_q, alu_a_d;
    logic [NB_DATA-1:0]    alu_b_q, alu_b_d;

    logic                  rx_avail;
    logic                  opc_bad;
    logic                  rx_pop;
    logic                  tx_push;
    logic [NB_DATA-1:0]    tx_data;

    // run_q clears with reset so no RX pop can be issued while reset is held
    assign rx_avail = run_q & ~i_fifo_rx_empty;
    assign opc_bad  = (op_byte_q >> NB_OPCODE) != '0;
`ifdef FRAME_CTRL_CHECKSUM_EN
    assign chk_bad  = (op_byte_q ^ a_q ^ b_q) != chk_q;
`endif

    always_comb begin
        state_d      = state_q;
        op_byte_d    = op_byte_q;
        a_d          = a_q;
`ifdef FRAME_CTRL_CHECKSUM_EN
        b_d          = b_q;
        chk_d        = chk_q;
`endif
        status_d     = status_q;
        result_d     = result_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        run_d        = 1'b1;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rx_pop       = 1'b0;
        tx_push      = 1'b0;
        tx_data      = '0;

        case (state_q)
            IDLE: begin
                if (rx_avail) begin
                    rx_pop = 1'b1;
                    if (i_data_to_read == SOF_BYTE) state_d = GET_OP;
                end
            end
            GET_OP: begin
                if (rx_avail) begin
                    rx_pop    = 1'b1;
                    op_byte_d = i_data_to_read;
                    state_d   = GET_A;
                end
            end
            GET_A: begin
                if (rx_avail) begin
                    rx_pop  = 1'b1;
                    a_d     = i_data_to_read;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (rx_avail) begin
                    rx_pop = 1'b1;
`ifdef FRAME_CTRL_CHECKSUM_EN
                    b_d     = i_data_to_read;
                    state_d = GET_CHK;
`else
                    alu_opcode_d = op_byte_q[NB_OPCODE-1:0];
                    alu_a_d      = a_q;
                    alu_b_d      = i_data_to_read;
                    state_d      = EXEC;
`endif
                end
            end
            GET_CHK: begin
`ifdef FRAME_CTRL_CHECKSUM_EN
                if (rx_avail) begin
                    rx_pop       = 1'b1;
                    chk_d        = i_data_to_read;
                    alu_opcode_d = op_byte_q[NB_OPCODE-1:0];
                    alu_a_d      = a_q;
                    alu_b_d      = b_q;
                    state_d      = EXEC;
                end
`else
                state_d = IDLE;
`endif
            end
            EXEC: begin
                // operands were loaded on entry, so i_alu_result has settled by the end of this cycle
`ifdef FRAME_CTRL_CHECKSUM_EN
                if (chk_bad)      status_d = ST_CHK;
                else if (opc_bad) status_d = ST_OPC;
                else              status_d = ST_OK;
`else
                status_d = opc_bad ? ST_OPC : ST_OK;
`endif
                result_d = (status_d == ST_OK) ? i_alu_result : '0;
                state_d  = SEND_SOF;
            end
            SEND_SOF: begin
                tx_data = SOF_BYTE;
                if (!i_fifo_tx_full) begin
                    tx_push = 1'b1;
                    state_d = SEND_RES;
                end
            end
            SEND_RES: begin
                tx_data = result_q;
                if (!i_fifo_tx_full) begin
                    tx_push = 1'b1;
                    state_d = SEND_STAT;
                end
            end
            SEND_STAT: begin
                tx_data = status_q;
                if (!i_fifo_tx_full) begin
                    tx_push = 1'b1;
                    state_d = IDLE;
                    if (status_q != ST_OK && err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // inter-byte watchdog: only runs while a frame is partially received
        if (state_q inside {GET_OP, GET_A, GET_B, GET_CHK}) begin
            if (rx_avail) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d    = '0;
                status_d = ST_TMO;
                result_d = '0;
                state_d  = SEND_SOF;
            end else begin
                tmo_d = tmo_q + NB_TIMEOUT'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            op_byte_q    <= '0;
            a_q          <= '0;
`ifdef FRAME_CTRL_CHECKSUM_EN
            b_q          <= '0;
            chk_q        <= '0;
`endif
            status_q     <= '0;
            result_q     <= '0;
            tmo_q        <= '0;
            err_q        <= '0;
            run_q        <= 1'b0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_byte_q    <= op_byte_d;
            a_q          <= a_d;
`ifdef FRAME_CTRL_CHECKSUM_EN
            b_q          <= b_d;
            chk_q        <= chk_d;
`endif
            status_q     <= status_d;
            result_q     <= result_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            run_q        <= run_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
        end
    end

    assign o_fifo_rx_read  = rx_pop;
    assign o_fifo_tx_write = tx_push;
    assign o_data_to_write = tx_data;
    assign o_alu_opcode    = alu_opcode_q;
    assign o_alu_op_A      = alu_a_q;
    assign o_alu_op_B      = alu_b_q;
    assign o_busy          = (state_q != IDLE);
    assign o_err_count     = err_q;

endmodule

// File: tb/tb_frame_ctrl.sv
// Scoreboard bench for frame_ctrl: frames are queued into a modelled RX FIFO, expected
// responses are pushed at issue time and a monitor pops/compares every TX write.
`timescale 1ns/1ps
module tb_frame_ctrl;

    localparam int          LIMIT = 16;
    localparam logic [7:0]  SOF   = 8'hA5;
`ifdef FRAME_CTRL_CHECKSUM_EN
    localparam bit          CHK_EN = 1'b1;
`else
    localparam bit          CHK_EN = 1'b0;
`endif
    localparam int          FLEN  = CHK_EN ? 5 : 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       tx_full;
    logic [7:0] alu_result;
    logic       rx_read;
    logic       tx_write;
    logic [7:0] tx_data;
    logic [5:0] alu_opcode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic [7:0] err_count;

    typedef struct { logic [7:0] data; int gap; } rx_item_t;
    typedef struct { logic [7:0] data; int kind; } tx_item_t;   // kind: 0 SOF, 1 result, 2 status

    rx_item_t   rx_q[$];
    tx_item_t   exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         gap_cnt = 0;
    int         pops = 0;
    int         force_full = 0;
    bit         hold_on_sof = 1'b0;
    bit         rand_full = 1'b1;
    bit         err_pending = 1'b0;
    logic [7:0] err_exp = 8'h00;

    always #5 clk = ~clk;

    frame_ctrl #(
        .TIMEOUT_LIMIT(LIMIT)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_data_to_read  (rx_data),
        .i_fifo_rx_empty (rx_empty),
        .i_fifo_tx_full  (tx_full),
        .i_alu_result    (alu_result),
        .o_fifo_rx_read  (rx_read),
        .o_fifo_tx_write (tx_write),
        .o_data_to_write (tx_data),
        .o_alu_opcode    (alu_opcode),
        .o_alu_op_A      (op_a),
        .o_alu_op_B      (op_b),
        .o_busy          (busy),
        .o_err_count     (err_count)
    );

    // Bench-side ALU; the reference model evaluates the same rule directly on frame bytes.
    function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            default: return {a[3:0], b[3:0]};
        endcase
    endfunction

    assign alu_result = alu_f(alu_opcode, op_a, op_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic push_rx(input logic [7:0] d, input int gap);
        rx_item_t it;
        it.data = d;
        it.gap  = gap;
        rx_q.push_back(it);
    endtask

    task automatic push_exp(input logic [7:0] d, input int kind);
        tx_item_t it;
        it.data = d;
        it.kind = kind;
        exp_q.push_back(it);
    endtask

    // Queue a frame (first 'keep' bytes only) and its expected response.
    task automatic issue_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] chk, input int keep, input int lead_gap, input int gap_max);
        logic [7:0] bytes [5];
        logic [7:0] st;
        logic [7:0] res;
        bytes[0] = SOF;
        bytes[1] = op;
        bytes[2] = a;
        bytes[3] = b;
        bytes[4] = chk;
        for (int i = 0; i < keep && i < FLEN; i++)
            push_rx(bytes[i], (i == 0) ? lead_gap : int'($urandom_range(0, gap_max)));
        if (keep < FLEN)                         st = 8'h03;
        else if (CHK_EN && chk != (op ^ a ^ b))  st = 8'h01;
        else if (op[7:6] != 2'b00)               st = 8'h02;
        else                                     st = 8'h00;
        res = (st == 8'h00) ? alu_f(op[5:0], a, b) : 8'h00;
        push_exp(SOF, 0);
        push_exp(res, 1);
        push_exp(st, 2);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rx_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("responses_pending", exp_q.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_read", rx_read, 0);
        check("rst_tx_write", tx_write, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_busy", busy, 0);
        check("rst_err_count", err_count, 0);
    endtask

    // RX FIFO model, TX-full generator and scoreboard monitor
    initial begin
        tx_item_t e;
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        tx_full  = 1'b0;
        forever begin
            @(negedge clk);
            if (force_full > 0) begin
                tx_full = 1'b1;
                force_full--;
            end else begin
                tx_full = rand_full && ($urandom_range(0, 3) == 0);
            end
            if (rx_q.size() > 0 && gap_cnt >= rx_q[0].gap) begin
                rx_empty = 1'b0;
                rx_data  = rx_q[0].data;
            end else begin
                rx_empty = 1'b1;
                rx_data  = 8'($urandom);
                if (rx_q.size() > 0) gap_cnt++;
                else                 gap_cnt = 0;
            end
            #1;
            if (err_pending) begin
                err_pending = 1'b0;
                check("err_count", err_count, err_exp);
            end
            if (rx_read) begin
                check("pop_when_empty", rx_empty, 0);
                if (!rx_empty) begin
                    void'(rx_q.pop_front());
                    gap_cnt = 0;
                    pops++;
                end
            end
            if (tx_write) begin
                check("tx_write_while_full", tx_full, 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected: got %02h, required no write", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("tx kind %0d byte %02h expected %02h", e.kind, tx_data, e.data);
                    check("tx_byte", tx_data, e.data);
                    if (e.kind == 2) begin
                        if (e.data != 8'h00 && err_exp != 8'hFF) err_exp++;
                        err_pending = 1'b1;
                    end else if (e.kind == 0 && hold_on_sof) begin
                        hold_on_sof = 1'b0;
                        force_full  = 10;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op, a, b, chk, gb;
        int         kind, keep, ng, next_gap, n, target;

        // reset with a byte waiting in the RX FIFO
        push_rx(8'h11, 0);
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drain(200);

        // ALU add, with TX FIFO held full for 10 cycles once SOF is out
        hold_on_sof = 1'b1;
        issue_frame(8'h20, 8'h05, 8'h03, 8'h26, FLEN, 0, 0);
        drain(400);
        // corrupted checksum
        issue_frame(8'h20, 8'h05, 8'h03, 8'h27, FLEN, 0, 0);
        drain(400);
        // leading garbage, then opcode with reserved bits set
        push_rx(8'h11, 0);
        push_rx(8'h22, 0);
        issue_frame(8'hE0, 8'h01, 8'h01, 8'hE0, FLEN, 0, 0);
        drain(400);
        // truncated frame must time out and return to IDLE
        issue_frame(8'h20, 8'h05, 8'h03, 8'h26, 2, 0, 0);
        drain(400);
        check("busy_after_timeout", busy, 0);

        // randomized frames
        next_gap = 0;
        for (int f = 0; f < 60; f++) begin
            ng = int'($urandom_range(0, 2));
            for (int g = 0; g < ng; g++) begin
                gb = 8'($urandom);
                if (gb == SOF) gb = 8'h3C;
                push_rx(gb, (g == 0) ? next_gap : int'($urandom_range(0, 3)));
            end
            kind = int'($urandom_range(0, 9));
            op   = 8'($urandom_range(0, 63));
            if (kind < 2) op[7:6] = 2'($urandom_range(1, 3));
            a    = 8'($urandom);
            b    = 8'($urandom);
            chk  = op ^ a ^ b;
            if (kind == 2 || kind == 3) chk = chk ^ 8'($urandom_range(1, 255));
            keep = (kind == 4) ? int'($urandom_range(1, FLEN - 1)) : FLEN;
            issue_frame(op, a, b, chk, keep, (ng == 0) ? next_gap : int'($urandom_range(0, 3)), 3);
            next_gap = (keep < FLEN) ? LIMIT + 4 : 0;
        end
        drain(20000);

        // asynchronous reset while waiting for operand B
        target = pops + 3;
        push_rx(SOF, 0);
        push_rx(8'h20, 0);
        push_rx(8'h05, 0);
        push_rx(8'h03, 8);
        n = 0;
        while (pops < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("reset_test_pops", pops, target);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        err_exp = 8'h00;
        repeat (12) @(posedge clk);
        #3;
        check("rx_present_in_reset", rx_empty, 0);
        check("rx_read_in_reset", rx_read, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        issue_frame(8'h20, 8'h05, 8'h03, 8'h26, FLEN, 2, 2);
        drain(400);

        check("final_err_count", err_count, err_exp);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
